// File: rtl/uart_cmd_responder.sv
// Command responder behind the UART: turns "W addr data" / "R addr" packets into
// register-bus accesses and returns one response byte. Define CMD_CHECKSUM_EN for a trailing XOR checksum byte.
module uart_cmd_responder #(
   parameter int         TIMEOUT = 50000,
   parameter logic [7:0] OP_WR   = 8'h57,
   parameter logic [7:0] OP_RD   = 8'h52,
   parameter logic [7:0] ACK     = 8'h4B,
   parameter logic [7:0] NAK     = 8'h3F
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       reg_we,
   output logic       reg_re,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic       overrun,
   output logic       timeout
);

   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_ADDR,
      S_GET_DATA,
      S_EXEC,
      S_RD_WAIT,
      S_SEND
`ifdef CMD_CHECKSUM_EN
      , S_GET_SUM
`endif
   } state_t;

`ifdef CMD_CHECKSUM_EN
   localparam state_t     S_AFTER_FIELDS = S_GET_SUM;
   localparam logic [7:0] SUM_BAD        = 8'h21;
`else
   localparam state_t     S_AFTER_FIELDS = S_EXEC;
`endif

   state_t          r_state;
   state_t          w_next;
   logic            r_isWrite;
   logic [7:0]      r_resp;
   logic [7:0]      r_txHold;
   logic [7:0]      r_regAddr;
   logic [7:0]      r_regWdata;
   logic            r_overrun;
   logic            r_timeout;
   logic [CW-1:0]   r_toCnt;
   logic            w_isOp;
   logic            w_timed;
   logic            w_toFire;
   logic            w_lateByte;
`ifdef CMD_CHECKSUM_EN
   logic [7:0]      r_sum;
   logic            w_sumOk;
`endif

   assign w_isOp     = (rx_data == OP_WR) || (rx_data == OP_RD);
   assign w_lateByte = rx_valid && ((r_state == S_EXEC) || (r_state == S_RD_WAIT) || (r_state == S_SEND));
`ifdef CMD_CHECKSUM_EN
   assign w_sumOk    = (rx_data == r_sum);
`endif

   always_comb begin
      w_timed = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
`ifdef CMD_CHECKSUM_EN
      if (r_state == S_GET_SUM) w_timed = 1'b1;
`endif
   end

   // A byte arriving on the terminal count takes priority over the timeout.
   assign w_toFire = w_timed && !rx_valid && (r_toCnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (rx_valid) w_next = w_isOp ? S_GET_ADDR : S_SEND;
         end
         S_GET_ADDR: begin
            if (rx_valid)      w_next = r_isWrite ? S_GET_DATA : S_AFTER_FIELDS;
            else if (w_toFire) w_next = S_IDLE;
         end
         S_GET_DATA: begin
            if (rx_valid)      w_next = S_AFTER_FIELDS;
            else if (w_toFire) w_next = S_IDLE;
         end
`ifdef CMD_CHECKSUM_EN
         S_GET_SUM: begin
            if (rx_valid)      w_next = w_sumOk ? S_EXEC : S_SEND;
            else if (w_toFire) w_next = S_IDLE;
         end
`endif
         S_EXEC:    w_next = r_isWrite ? S_SEND : S_RD_WAIT;
         S_RD_WAIT: w_next = S_SEND;
         S_SEND: begin
            if (!tx_busy) w_next = S_IDLE;
         end
         default:   w_next = S_IDLE;
      endcase
   end

   // tx_data shows the pending response only in the tx_start cycle, then holds it.
   always_comb begin
      reg_we   = 1'b0;
      reg_re   = 1'b0;
      tx_start = 1'b0;
      busy     = (r_state != S_IDLE);
      case (r_state)
         S_EXEC: begin
            reg_we = r_isWrite;
            reg_re = !r_isWrite;
         end
         S_SEND:  tx_start = !tx_busy;
         default: ;
      endcase
      tx_data = tx_start ? r_resp : r_txHold;
   end

   always_ff @(posedge clk) begin
      if (rst || !w_timed || rx_valid || w_toFire) r_toCnt <= '0;
      else                                        r_toCnt <= r_toCnt + CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_isWrite  <= 1'b0;
         r_resp     <= 8'h00;
         r_txHold   <= 8'h00;
         r_regAddr  <= 8'h00;
         r_regWdata <= 8'h00;
         r_overrun  <= 1'b0;
         r_timeout  <= 1'b0;
`ifdef CMD_CHECKSUM_EN
         r_sum      <= 8'h00;
`endif
      end else begin
         r_timeout <= w_toFire;
         if (w_lateByte) r_overrun <= 1'b1;
         if (tx_start)   r_txHold  <= r_resp;
         case (r_state)
            S_IDLE: begin
               if (rx_valid) begin
                  if (w_isOp) r_isWrite <= (rx_data == OP_WR);
                  else        r_resp    <= NAK;
`ifdef CMD_CHECKSUM_EN
                  r_sum <= rx_data;
`endif
               end
            end
            S_GET_ADDR: begin
               if (rx_valid) begin
                  r_regAddr <= rx_data;
`ifdef CMD_CHECKSUM_EN
                  r_sum <= r_sum ^ rx_data;
`endif
               end
            end
            S_GET_DATA: begin
               if (rx_valid) begin
                  r_regWdata <= rx_data;
`ifdef CMD_CHECKSUM_EN
                  r_sum <= r_sum ^ rx_data;
`endif
               end
            end
`ifdef CMD_CHECKSUM_EN
            S_GET_SUM: begin
               if (rx_valid && !w_sumOk) r_resp <= SUM_BAD;
            end
`endif
            S_EXEC: begin
               if (r_isWrite) r_resp <= ACK;
            end
            S_RD_WAIT: r_resp <= reg_rdata;
            default: ;
         endcase
      end
   end

   assign reg_addr  = r_regAddr;
   assign reg_wdata = r_regWdata;
   assign overrun   = r_overrun;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: a packet-level model queues expected bus
// accesses and response bytes; a negedge monitor pops and compares them.
module tb_uart_cmd_responder;

   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_busy = 1'b0;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       busy;
   logic       overrun;
   logic       timeout;

   typedef struct {
      bit         isWrite;
      logic [7:0] addr;
      logic [7:0] data;
   } busEv_t;

   busEv_t     expBus[$];
   logic [7:0] expTx[$];
   logic [7:0] pkt[$];
   logic [7:0] devMem[256];
   logic [7:0] modelMem[256];
   int         tests = 0;
   int         fails = 0;
   int         txCount = 0;
   int         actTimeouts = 0;
   int         expTimeouts = 0;
   bit         busyForce = 1'b0;
   bit         randBusy = 1'b0;

   always #5 clk = ~clk;

   uart_cmd_responder #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
      .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .busy(busy),
      .overrun(overrun), .timeout(timeout)
   );

   // Register file on the bus side; read data is junk except the cycle after reg_re.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) devMem[i] <= 8'(i) ^ 8'h1E;
      end else if (reg_we) begin
         devMem[reg_addr] <= reg_wdata;
      end
      reg_rdata <= reg_re ? devMem[reg_addr] : 8'($urandom);
   end

   always @(posedge clk) begin
      #2;
      tx_busy = busyForce ? 1'b1 : (randBusy ? ($urandom_range(0, 3) == 0) : 1'b0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      tests++;
      fails++;
      $display("[TB] FAIL %s: got an event, expected none", name);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (tx_start) begin
            txCount++;
            if (expTx.size() == 0) unexpected("tx_start");
            else check("tx_data", {24'h0, tx_data}, {24'h0, expTx.pop_front()});
         end
         if (reg_we && reg_re) unexpected("we_and_re");
         else if (reg_we || reg_re) begin
            if (expBus.size() == 0) unexpected("bus_strobe");
            else begin
               busEv_t e;
               e = expBus.pop_front();
               check("bus_kind", {31'h0, reg_we}, {31'h0, e.isWrite});
               check("bus_addr", {24'h0, reg_addr}, {24'h0, e.addr});
               if (e.isWrite) check("bus_wdata", {24'h0, reg_wdata}, {24'h0, e.data});
            end
         end
         if (timeout) actTimeouts++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic sendPkt(input int gap);
`ifdef CMD_CHECKSUM_EN
      logic [7:0] s;
      s = 8'h00;
      foreach (pkt[i]) s = s ^ pkt[i];
      pkt.push_back(s);
`endif
      foreach (pkt[i]) begin
         if (i > 0) repeat ((gap < 0) ? $urandom_range(0, 4) : gap) tick();
         applyStimulus(pkt[i]);
      end
   endtask

   task automatic modelWrite(input logic [7:0] a, input logic [7:0] d, input int gap);
      busEv_t e;
      e.isWrite = 1'b1;
      e.addr    = a;
      e.data    = d;
      expBus.push_back(e);
      expTx.push_back(8'h4B);
      modelMem[a] = d;
      pkt = {8'h57, a, d};
      sendPkt(gap);
   endtask

   task automatic modelRead(input logic [7:0] a, input int gap);
      busEv_t e;
      e.isWrite = 1'b0;
      e.addr    = a;
      e.data    = 8'h00;
      expBus.push_back(e);
      expTx.push_back(modelMem[a]);
      pkt = {8'h52, a};
      sendPkt(gap);
   endtask

   task automatic modelUnknown(input logic [7:0] b);
      expTx.push_back(8'h3F);
      applyStimulus(b);
   endtask

   task automatic modelReset();
      rst = 1'b1;
      tick();
      for (int i = 0; i < 256; i++) modelMem[i] = 8'(i) ^ 8'h1E;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      check(name, act, exp);
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      checkOutput("idle_reached", {31'h0, busy}, 32'h0);
   endtask

   task automatic timeoutProbe(input int nBytes);
      int n;
      applyStimulus(8'h57);
      if (nBytes > 1) applyStimulus(8'h33);
      n = 0;
      while (!timeout && n < 100) begin
         tick();
         n++;
      end
      expTimeouts++;
      checkOutput("timeout_delay", n, TO);
      checkOutput("timeout_idle", {31'h0, busy}, 32'h0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_tx_start"}, {31'h0, tx_start}, 32'h0);
      checkOutput({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
      checkOutput({tag, "_reg_we"}, {31'h0, reg_we}, 32'h0);
      checkOutput({tag, "_reg_re"}, {31'h0, reg_re}, 32'h0);
      checkOutput({tag, "_reg_addr"}, {24'h0, reg_addr}, 32'h0);
      checkOutput({tag, "_reg_wdata"}, {24'h0, reg_wdata}, 32'h0);
      checkOutput({tag, "_overrun"}, {31'h0, overrun}, 32'h0);
      checkOutput({tag, "_timeout"}, {31'h0, timeout}, 32'h0);
      checkOutput({tag, "_busy"}, {31'h0, busy}, 32'h0);
   endtask

   initial begin
      int txBefore;
      logic [7:0] b;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      modelReset();
      tick();
      checkAllZero("reset");
      rst = 1'b0;
      tick();

      modelWrite(8'h10, 8'hA5, 0);
      checkOutput("wr_we_latency", {31'h0, reg_we}, 32'h1);
      tick();
      checkOutput("wr_tx_latency", {31'h0, tx_start}, 32'h1);
      waitIdle();

      modelRead(8'h22, 0);
      checkOutput("rd_re_latency", {31'h0, reg_re}, 32'h1);
      tick();
      tick();
      checkOutput("rd_tx_latency", {31'h0, tx_start}, 32'h1);
      waitIdle();

      modelUnknown(8'h41);
      checkOutput("nak_start", {31'h0, tx_start}, 32'h1);
      tick();
      checkOutput("nak_idle", {31'h0, busy}, 32'h0);

      timeoutProbe(1);
      modelRead(8'h05, -1);
      waitIdle();
      timeoutProbe(2);

      modelWrite(8'h44, 8'h99, TO - 1);
      waitIdle();
      modelRead(8'h44, TO - 1);
      waitIdle();

`ifdef CMD_CHECKSUM_EN
      expBus.push_back('{isWrite: 1'b1, addr: 8'h01, data: 8'h02});
      expTx.push_back(8'h4B);
      modelMem[1] = 8'h02;
      foreach (pkt[i]) pkt.delete(i);
      pkt = {8'h57, 8'h01, 8'h02, 8'h54};
      foreach (pkt[i]) applyStimulus(pkt[i]);
      waitIdle();
      expTx.push_back(8'h21);
      pkt = {8'h57, 8'h01, 8'h02, 8'h00};
      foreach (pkt[i]) applyStimulus(pkt[i]);
      waitIdle();
`endif

      randBusy = 1'b1;
      for (int k = 0; k < 40; k++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind < 4) modelWrite(8'($urandom), 8'($urandom), -1);
         else if (kind < 8) modelRead(8'($urandom_range(0, 15)), -1);
         else begin
            b = 8'($urandom);
            while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
            modelUnknown(b);
         end
         waitIdle();
      end
      randBusy = 1'b0;
      tick();

      checkOutput("overrun_clear", {31'h0, overrun}, 32'h0);
      busyForce = 1'b1;
      tick();
      tick();
      txBefore = txCount;
      modelWrite(8'h01, 8'h02, 0);
      repeat (4) tick();
      checkOutput("send_held_busy", {31'h0, busy}, 32'h1);
      checkOutput("send_withheld", txCount, txBefore);
      applyStimulus(8'hEE);
      checkOutput("overrun_set", {31'h0, overrun}, 32'h1);
      busyForce = 1'b0;
      waitIdle();
      checkOutput("send_once", txCount, txBefore + 1);
      modelRead(8'h01, -1);
      waitIdle();
      checkOutput("overrun_sticky", {31'h0, overrun}, 32'h1);

      applyStimulus(8'h57);
      applyStimulus(8'h01);
      modelReset();
      checkAllZero("midreset");
      rst = 1'b0;
      tick();
      tick();
      checkOutput("midreset_idle", {31'h0, busy}, 32'h0);
      modelRead(8'h01, -1);
      waitIdle();

      repeat (3) tick();
      checkOutput("tx_queue_drained", expTx.size(), 0);
      checkOutput("bus_queue_drained", expBus.size(), 0);
      checkOutput("timeout_count", actTimeouts, expTimeouts);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
Byte-level command responder on the far side of the UART link. It parses host command packets from received UART bytes and performs 8-bit register reads and writes on an internal register bus. It returns one response byte per command through the UART transmit path. It sits between the UART core (rx byte strobe in, tx start/busy out) and the display control register file.

Parameters:
TIMEOUT, 50000, clk cycles allowed between bytes of one packet before the packet is abandoned
OP_WR, 8'h57, opcode byte for write ('W')
OP_RD, 8'h52, opcode byte for read ('R')
ACK, 8'h4B, response byte to a successful write ('K')
NAK, 8'h3F, response byte to an unknown opcode ('?')

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_valid  in  1  one-cycle strobe: rx_data holds a new received byte
rx_data  in  8  received byte
tx_busy  in  1  UART transmitter busy
tx_start  out  1  one-cycle strobe: transmit tx_data
tx_data  out  8  response byte; held stable from tx_start until the next tx_start
reg_we  out  1  one-cycle register write strobe
reg_re  out  1  one-cycle register read strobe
reg_addr  out  8  register address
reg_wdata  out  8  register write data
reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky; set when a byte arrives in EXEC/RD_WAIT/SEND
timeout  out  1  one-cycle pulse when a partial packet is abandoned

Behaviour:
- Reset (rst high at a clk edge, any state) puts the FSM in IDLE and clears all of the following to 0: tx_start, tx_data, reg_we, reg_re, reg_addr, reg_wdata, overrun, timeout and the timeout counter. Reset mid-packet discards the packet with no response and no write.
- Packets: write = OP_WR, addr, data. Read = OP_RD, addr.
- IDLE:
  - rx_valid with OP_WR or OP_RD: latch the opcode, go to GET_ADDR.
  - Any other byte: set resp = NAK, go to SEND.
- GET_ADDR, on rx_valid: latch reg_addr.
  - Write: go to GET_DATA.
  - Read: go to EXEC (GET_SUM first when the feature is enabled).
- GET_DATA, on rx_valid: latch reg_wdata, then go to EXEC (GET_SUM when enabled).
- EXEC is one cycle.
  - Write: reg_we = 1, resp = ACK, go to SEND.
  - Read: reg_re = 1, go to RD_WAIT.
- RD_WAIT is one cycle: resp = reg_rdata, go to SEND.
- SEND:
  - Stay while tx_busy = 1.
  - On the first cycle with tx_busy = 0: tx_start = 1 and tx_data = resp for exactly one cycle, then go to IDLE.
- Latency: the write strobe occurs 1 cycle after the data byte's rx_valid. The response tx_start occurs 2 cycles after it (write) or 3 cycles after the addr byte (read), provided tx_busy is low.
- Timeout, in GET_ADDR, GET_DATA and GET_SUM:
  - The counter clears on entering the state and on each rx_valid, and otherwise increments.
  - When the counter reaches TIMEOUT-1: go to IDLE, pulse timeout, send no response.
  - If rx_valid and the terminal count fall in the same cycle, the byte wins and the timeout does not fire.
- rx_valid in EXEC, RD_WAIT or SEND: the byte is dropped and overrun is set. Only rst clears overrun.
- Only one outstanding response. A byte arriving in IDLE the same cycle SEND exits is not possible, because SEND exits to IDLE on the following edge.
- Register bus addresses wrap naturally in 8 bits; there is no range checking.

Optional Feature:
CMD_CHECKSUM_EN
- Defined:
  - Every packet carries a trailing checksum byte, taken in the GET_SUM state. The checksum is the XOR of all preceding packet bytes.
  - Match: proceed to EXEC.
  - Mismatch: no reg_we/reg_re, resp = 8'h21 ('!'), go to SEND.
  - GET_SUM is covered by the timeout.
- Undefined: there is no GET_SUM state and packets are as listed above.

Test Plan:
- Write: rx 57,10,A5 with tx_busy = 0.
  - reg_we pulses once with addr = 10 and wdata = A5.
  - tx_start with tx_data = 4B occurs 1 cycle after reg_we.
- Read: rx 52,22 with reg_rdata = 3C in the cycle after reg_re.
  - reg_re pulses once with addr = 22.
  - tx_start with tx_data = 3C; no reg_we.
- Unknown opcode: rx 41 -> tx_start with tx_data = 3F, no bus strobes, busy back to 0 the next cycle.
- Timeout: TIMEOUT = 20, rx 57 then silence.
  - timeout pulses 20 cycles later; no tx_start.
  - A following 52,05 is handled as a normal read.
- Busy/overrun:
  - Hold tx_busy = 1 after rx 57,01,02: tx_start is withheld until tx_busy falls, then pulses once with 4B.
  - An rx byte during SEND sets overrun = 1, which stays set until rst.
- Reset and checksum:
  - Assert rst after rx 57,01: no write, all outputs 0.
  - With CMD_CHECKSUM_EN: rx 57,01,02,54 writes; rx 57,01,02,00 gives tx_data = 21 and no reg_we.
